sad_min_selector: RTL and testbench

- Sits directly downstream of the processing-element array and consumes its per-candidate SAD results.
- The PEs run in lockstep, so each result beat carries NUM_PE SADs, one per PE lane, for consecutive candidate positions of the search window.
- The block tracks the minimum SAD over one full search pass and converts the winning candidate index into a signed motion vector.
- Outputs: best SAD, mv_x, mv_y, and a one-cycle valid pulse to the motion-vector consumer.

---
 rtl/sad_min_selector.sv | 98 +++++++++
 tb/tb_sad_min_selector.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sad_min_selector.sv
// sad_min_selector: tracks the minimum SAD over one search pass and converts its index to a signed motion vector
//   in_clk, in_rst_n         clock, asynchronous active-low reset
//   in_start                 begin or restart a pass (ignored while converting)
//   in_SAD_bus, in_SAD_valid NUM_PE SADs per beat, lane l carries candidate cand_count+l
//   out_min_SAD, out_mv_x/y  result of the last completed pass, held until the next pulse
//   out_mv_valid, out_busy   one-cycle result pulse, high while collecting or converting
module sad_min_selector #(
    parameter int MAX_DATA_WIDTH = 16,
    parameter int NUM_PE         = 4,
    parameter int SEARCH_RANGE   = 8,
    parameter int NUM_CANDIDATES = 289,
    parameter int IDX_WIDTH      = 9,
    parameter int MV_WIDTH       = 5
) (
    input  logic                             in_clk,
    input  logic                             in_rst_n,
    input  logic                             in_start,
    input  logic [NUM_PE*MAX_DATA_WIDTH-1:0] in_SAD_bus,
    input  logic                             in_SAD_valid,
    output logic [MAX_DATA_WIDTH-1:0]        out_min_SAD,
    output logic [MV_WIDTH-1:0]              out_mv_x,
    output logic [MV_WIDTH-1:0]              out_mv_y,
    output logic                             out_mv_valid,
    output logic                             out_busy
);
    localparam int SEARCH_DIM = 2*SEARCH_RANGE+1;
    localparam int CW = IDX_WIDTH+1;
    typedef enum logic [1:0] {IDLE, COLLECT, CONVERT} state_t;
    state_t state;
    logic [IDX_WIDTH-1:0] cand_count, best_idx, rem, row, beat_idx, next_idx;
    logic [MAX_DATA_WIDTH-1:0] best_SAD, beat_min;
    logic beat_found, update, final_beat;
    // strict compare in ascending lane order makes the lowest lane win on equal SADs
    always_comb begin
        beat_found = 1'b0;
        beat_min = '1;
        beat_idx = '0;
        for (int l = 0; l < NUM_PE; l++)
            if (({1'b0, cand_count} + CW'(l) < CW'(NUM_CANDIDATES)) &&
                (!beat_found || in_SAD_bus[l*MAX_DATA_WIDTH +: MAX_DATA_WIDTH] < beat_min)) begin
                beat_found = 1'b1;
                beat_min = in_SAD_bus[l*MAX_DATA_WIDTH +: MAX_DATA_WIDTH];
                beat_idx = cand_count + IDX_WIDTH'(l);
            end
    end
    assign update = beat_found && (beat_min < best_SAD);
    assign next_idx = update ? beat_idx : best_idx;
    assign final_beat = {1'b0, cand_count} + CW'(NUM_PE) >= CW'(NUM_CANDIDATES);
    assign out_busy = state != IDLE;
    // CONVERT divides best_idx by SEARCH_DIM through repeated subtraction, one row per cycle
    always_ff @(posedge in_clk or negedge in_rst_n)
        if (!in_rst_n) begin
            state <= IDLE;
            cand_count <= '0;
            best_SAD <= '1;
            best_idx <= '0;
            rem <= '0;
            row <= '0;
            out_min_SAD <= '0;
            out_mv_x <= '0;
            out_mv_y <= '0;
            out_mv_valid <= 1'b0;
        end else begin
            out_mv_valid <= 1'b0;
            case (state)
                IDLE, COLLECT:
                    if (in_start) begin
                        state <= COLLECT;
                        cand_count <= '0;
                        best_SAD <= '1;
                        best_idx <= '0;
                    end else if (state == COLLECT && in_SAD_valid) begin
                        if (update) begin
                            best_SAD <= beat_min;
                            best_idx <= beat_idx;
                        end
                        cand_count <= cand_count + IDX_WIDTH'(NUM_PE);
                        if (final_beat) begin
                            state <= CONVERT;
                            rem <= next_idx;
                            row <= '0;
                        end
                    end
                CONVERT:
                    if (rem >= IDX_WIDTH'(SEARCH_DIM)) begin
                        rem <= rem - IDX_WIDTH'(SEARCH_DIM);
                        row <= row + IDX_WIDTH'(1);
                    end else begin
                        out_min_SAD <= best_SAD;
                        out_mv_x <= MV_WIDTH'(rem) - MV_WIDTH'(SEARCH_RANGE);
                        out_mv_y <= MV_WIDTH'(row) - MV_WIDTH'(SEARCH_RANGE);
                        out_mv_valid <= 1'b1;
                        state <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_sad_min_selector.sv
// tb_sad_min_selector: table-driven and scoreboard checks of sad_min_selector
module tb_sad_min_selector;
    logic in_clk = 0, in_rst_n = 1, in_start = 0, in_SAD_valid = 0;
    logic [63:0] in_SAD_bus = '0;
    logic [15:0] out_min_SAD;
    logic [4:0] out_mv_x, out_mv_y;
    logic out_mv_valid, out_busy;
    sad_min_selector dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_start(in_start),
        .in_SAD_bus(in_SAD_bus), .in_SAD_valid(in_SAD_valid),
        .out_min_SAD(out_min_SAD), .out_mv_x(out_mv_x), .out_mv_y(out_mv_y),
        .out_mv_valid(out_mv_valid), .out_busy(out_busy)
    );
    always #5 in_clk = ~in_clk;
    typedef struct {int sad; int x; int y; int cyc;} exp_t;
    typedef struct {int base; int i0; int v0; int i1; int v1; int i2; int v2; int tail; int bub;
                    int sad; int x; int y; int lat;} vec_t;
    exp_t sb[$];
    exp_t e;
    vec_t v[8];
    int sads[292];
    int cyc = 0, n_pass = 0, n_total = 0;
    int last_sad = 0, last_x = 0, last_y = 0;
    always @(posedge in_clk) cyc++;
    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask
    always @(negedge in_clk)
        if (in_rst_n && out_mv_valid) begin
            if (sb.size() == 0) check("unexpected_pulse", 1, 0);
            else begin
                e = sb.pop_front();
                check("min_sad", out_min_SAD, e.sad);
                check("mv_x", $signed(out_mv_x), e.x);
                check("mv_y", $signed(out_mv_y), e.y);
                check("latency_cycle", cyc, e.cyc);
                check("busy_at_pulse", out_busy, 0);
                last_sad = e.sad;
                last_x = e.x;
                last_y = e.y;
            end
        end
    task automatic fill(input int base, input int tail);
        for (int i = 0; i < 292; i++) sads[i] = i < 289 ? base : tail;
    endtask
    task automatic model(output int s, output int idx);
        s = 65535;
        idx = 0;
        for (int i = 0; i < 289; i++)
            if (sads[i] < s) begin
                s = sads[i];
                idx = i;
            end
    endtask
    task automatic drive_beat(input int b);
        for (int l = 0; l < 4; l++) in_SAD_bus[l*16 +: 16] = 16'(sads[b*4+l]);
        in_SAD_valid = 1;
        @(posedge in_clk);
        #1 in_SAD_valid = 0;
    endtask
    task automatic send_pass(input bit do_start, input int bub, input int esad, input int ex,
                             input int ey, input int elat);
        if (do_start) begin
            @(posedge in_clk);
            #1 in_start = 1;
            @(posedge in_clk);
            #1 in_start = 0;
            check("busy_collect", out_busy, 1);
        end
        for (int b = 0; b < 73; b++) begin
            if (b == 72) sb.push_back('{esad, ex, ey, cyc + 1 + elat});
            drive_beat(b);
            if (bub != 0 && b < 72) begin
                repeat ($urandom_range(1, 3)) @(posedge in_clk);
                #1;
            end
        end
    endtask
    task automatic drain();
        int i = 0;
        while (sb.size() > 0 && i < 40) begin
            @(posedge in_clk);
            i++;
        end
        if (sb.size() > 0) begin
            check("pulse_timeout", sb.size(), 0);
            sb.delete();
        end else begin
            @(negedge in_clk);
            check("hold_sad", out_min_SAD, last_sad);
            check("hold_mv_x", $signed(out_mv_x), last_x);
            check("hold_mv_y", $signed(out_mv_y), last_y);
            check("single_pulse", out_mv_valid, 0);
            check("busy_idle", out_busy, 0);
        end
    endtask
    task automatic run_vec(input vec_t t);
        fill(t.base, t.tail);
        if (t.i0 >= 0) sads[t.i0] = t.v0;
        if (t.i1 >= 0) sads[t.i1] = t.v1;
        if (t.i2 >= 0) sads[t.i2] = t.v2;
        send_pass(1, t.bub, t.sad, t.x, t.y, t.lat);
        drain();
    endtask
    initial begin
        int s, idx;
        v[0] = '{1000, 144, 5, -1, 0, -1, 0, 1000, 0, 5, 0, 0, 9};
        v[1] = '{50, 0, 0, 288, 0, -1, 0, 50, 0, 0, -8, -8, 1};
        v[2] = '{10, 288, 3, -1, 0, -1, 0, 0, 0, 3, 8, 8, 17};
        v[3] = '{100, 41, 7, 42, 7, -1, 0, 100, 1, 7, -1, -6, 3};
        v[4] = '{500, -1, 0, -1, 0, -1, 0, 500, 1, 500, -8, -8, 1};
        v[5] = '{65535, -1, 0, -1, 0, -1, 0, 0, 0, 65535, -8, -8, 1};
        v[6] = '{200, 16, 3, 17, 3, -1, 0, 200, 0, 3, 8, -8, 1};
        v[7] = '{9, 286, 4, 287, 2, 288, 2, 9, 1, 2, 7, 8, 17};
        #2 in_rst_n = 0;
        #1;
        check("rst_min_sad", out_min_SAD, 0);
        check("rst_mv_x", out_mv_x, 0);
        check("rst_mv_y", out_mv_y, 0);
        check("rst_valid", out_mv_valid, 0);
        check("rst_busy", out_busy, 0);
        repeat (2) @(posedge in_clk);
        #1 in_rst_n = 1;
        fill(0, 0);
        for (int b = 0; b < 3; b++) drive_beat(b);
        check("idle_ignores_valid", out_busy, 0);
        for (int i = 0; i < 8; i++) run_vec(v[i]);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 292; i++) sads[i] = r == 0 ? $urandom_range(0, 65535) : $urandom_range(5, 40);
            model(s, idx);
            send_pass(1, 1, s, idx % 17 - 8, idx / 17 - 8, idx / 17 + 1);
            drain();
        end
        fill(100, 100);
        sads[5] = 2;
        @(posedge in_clk);
        #1 in_start = 1;
        @(posedge in_clk);
        #1 in_start = 0;
        for (int b = 0; b < 20; b++) drive_beat(b);
        in_SAD_bus = '0;
        in_start = 1;
        in_SAD_valid = 1;
        @(posedge in_clk);
        #1 in_start = 0;
        in_SAD_valid = 0;
        fill(100, 100);
        sads[18] = 9;
        send_pass(0, 0, 9, -7, -7, 2);
        drain();
        fill(10, 10);
        sads[288] = 3;
        send_pass(1, 0, 3, 8, 8, 17);
        repeat (5) @(posedge in_clk);
        #2 in_rst_n = 0;
        #1;
        check("abort_min_sad", out_min_SAD, 0);
        check("abort_mv_x", out_mv_x, 0);
        check("abort_mv_y", out_mv_y, 0);
        check("abort_valid", out_mv_valid, 0);
        check("abort_busy", out_busy, 0);
        sb.delete();
        repeat (3) @(posedge in_clk);
        #1 in_rst_n = 1;
        repeat (25) @(posedge in_clk);
        #1 check("abort_stays_idle", out_busy, 0);
        run_vec(v[0]);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
